mips_ctrl_ws: RTL and testbench
===============================

MIPS_CTRL_WS -- requirements
Module: mips_ctrl_ws

Interface
REQ-001 The block SHALL provide parameter TIMEOUT, default 16: max consecutive cycles a memory state waits on mem_ready low before error.
REQ-002 The block SHALL provide parameter CNT_W, default 32: width of instr_count.
REQ-003 The block SHALL provide parameter HAS_JAL, default 1: 1 enables jal (opcode 000011); 0 treats it as illegal.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 opcode  in  6  IR[31:26] from datapath.
REQ-007 mem_ready  in  1  memory completes current access this cycle.
REQ-008 alu_op  out  2  00 add, 01 sub, 10 funct-decoded, 11 immediate-op decoded from opcode.
REQ-009 alu_src_b  out  2  00 B reg, 01 const 4, 10 ext imm, 11 ext imm<<2.
REQ-010 pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-011 wreg_dst  out  2  00 rt, 01 rd, 10 r31.
REQ-012 wreg_data_sel  out  2  00 ALUOut, 01 MDR, 10 PC.
REQ-013 mem_read, mem_write, i_or_d, reg_write, ir_write, pc_write, pc_write_cond, alu_src_a, imm_com  out  1 each  datapath strobes/selects (i_or_d 1 = data address; alu_src_a 1 = A reg; imm_com 1 = zero-extend).
REQ-014 state  out  4  current FSM state encoding.
REQ-015 error_code  out  2  00 none, 01 memory timeout, 10 illegal opcode; sticky.
REQ-016 instr_count  out  CNT_W  retired-instruction counter.

Function
REQ-017 States SHALL be FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, BEQ, JUMP, JAL, I_EXEC, I_WB, ERROR; encoded 0..13 in that order.
REQ-018 Outputs SHALL be Moore (decoded from state), except ir_write and pc_write in FETCH, which SHALL equal mem_ready.
REQ-019 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; stay while mem_ready=0; to DECODE when mem_ready=1.
REQ-020 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next by opcode: 100011/101011->MEM_ADDR, 000000->R_EXEC, 000100->BEQ, 000010->JUMP, 000011->JAL (HAS_JAL=1), 001000/001100/001101/001010->I_EXEC, else ERROR with error_code=10.
REQ-021 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00, imm_com=0; lw->MEM_RD, sw->MEM_WR.
REQ-022 MEM_RD: mem_read=1, i_or_d=1 held until mem_ready=1, then MEM_WB; MEM_WB: reg_write=1, wreg_dst=00, wreg_data_sel=01, ->FETCH.
REQ-023 MEM_WR: mem_write=1, i_or_d=1 held until mem_ready=1, then FETCH.
REQ-024 R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 ->R_WB; R_WB: reg_write=1, wreg_dst=01, wreg_data_sel=00 ->FETCH.
REQ-025 BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 ->FETCH.
REQ-026 JUMP: pc_write=1, pc_source=10 ->FETCH; JAL: same plus reg_write=1, wreg_dst=10, wreg_data_sel=10 ->FETCH.
REQ-027 I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=11, imm_com=1 for 001100/001101 else 0 ->I_WB; I_WB: reg_write=1, wreg_dst=00, wreg_data_sel=00 ->FETCH.
REQ-028 Memory handshake: mem_read/mem_write/i_or_d SHALL stay constant every cycle of a wait; never both mem_read and mem_write high.
REQ-029 A wait counter SHALL clear on entry to FETCH/MEM_RD/MEM_WR and increment each cycle there with mem_ready=0; when it reaches TIMEOUT with mem_ready still 0, next state SHALL be ERROR, error_code=01; mem_ready=1 on that same cycle wins (normal progress).
REQ-030 ERROR: all strobes 0, terminal until rst; error_code holds.
REQ-031 instr_count SHALL increment by 1 on each transition into FETCH from a non-FETCH, non-ERROR state; wraps modulo 2^CNT_W.
REQ-032 All strobes not listed for a state SHALL be 0; unlisted selects 00.

Reset
REQ-033 rst=1 at any clock edge SHALL force state=FETCH, error_code=00, instr_count=0, wait counter=0, overriding any in-progress access or ERROR.

Structure
REQ-034 State encodings, opcode constants and select encodings SHALL live in shared package mips_pkg; the wait counter MAY be sub-module mips_wait_timer.

Verification
REQ-035 Reset, then lw, mem_ready high always -> states 0,1,2,3,4,0; reg_write only in MEM_WB; instr_count=1.
REQ-036 sw with mem_ready low 5 cycles in MEM_WR -> mem_write,i_or_d=1 stable 6 cycles, then FETCH, count+1.
REQ-037 TIMEOUT=4, mem_ready stuck 0 in FETCH -> ERROR after cycle 4, error_code=01, strobes 0.
REQ-038 opcode 111111 in DECODE -> ERROR, error_code=10; HAS_JAL=0 with 000011 -> same.
REQ-039 rst pulsed mid MEM_RD wait -> FETCH next cycle, count=0; CNT_W=4, 16 retirements -> count wraps to 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// datapath select values and the bundled control-word type.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BEQ      = 4'd8,
        S_JUMP     = 4'd9,
        S_JAL      = 4'd10,
        S_I_EXEC   = 4'd11,
        S_I_WB     = 4'd12,
        S_ERROR    = 4'd13
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_IMM   = 2'b11;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] DST_RT  = 2'b00;
    localparam logic [1:0] DST_RD  = 2'b01;
    localparam logic [1:0] DST_R31 = 2'b10;

    localparam logic [1:0] WD_ALUOUT = 2'b00;
    localparam logic [1:0] WD_MDR    = 2'b01;
    localparam logic [1:0] WD_PC     = 2'b10;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL = 2'b10;

    typedef struct packed {
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] wreg_dst;
        logic [1:0] wreg_data_sel;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       reg_write;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       alu_src_a;
        logic       imm_com;
    } ctrl_t;

    // States in which the controller stalls on mem_ready.
    function automatic logic is_wait_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mips_ctrl_ws_if.sv
// Controller <-> datapath/memory bundle; master is the controller side.
interface mips_ctrl_ws_if #(
    parameter int CNT_W = 32
) ();

    logic [5:0]       opcode;
    logic             mem_ready;
    logic [1:0]       alu_op;
    logic [1:0]       alu_src_b;
    logic [1:0]       pc_source;
    logic [1:0]       wreg_dst;
    logic [1:0]       wreg_data_sel;
    logic             mem_read;
    logic             mem_write;
    logic             i_or_d;
    logic             reg_write;
    logic             ir_write;
    logic             pc_write;
    logic             pc_write_cond;
    logic             alu_src_a;
    logic             imm_com;
    logic [3:0]       state;
    logic [1:0]       error_code;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, mem_ready,
        output alu_op, alu_src_b, pc_source, wreg_dst, wreg_data_sel,
               mem_read, mem_write, i_or_d, reg_write, ir_write, pc_write,
               pc_write_cond, alu_src_a, imm_com, state, error_code, instr_count
    );

    modport slave (
        output opcode, mem_ready,
        input  alu_op, alu_src_b, pc_source, wreg_dst, wreg_data_sel,
               mem_read, mem_write, i_or_d, reg_write, ir_write, pc_write,
               pc_write_cond, alu_src_a, imm_com, state, error_code, instr_count
    );

endinterface

// File: rtl/mips_wait_timer.sv
// Counts consecutive stalled cycles in a memory state; flags the cycle on
// which a TIMEOUT-th stalled cycle is being completed.
module mips_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign expired = waiting && (count_q == CW'(TIMEOUT - 1));

    // Any non-stalled cycle clears the count, so entry to a wait state starts at zero.
    always_comb begin
        count_d = '0;
        if (waiting && !expired) begin
            count_d = count_q + CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mips_ctrl_ws.sv
// Multicycle MIPS control FSM with memory wait states, timeout detection,
// sticky error reporting and a retired-instruction counter.
module mips_ctrl_ws
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32,
    parameter int HAS_JAL = 1
) (
    input logic          clk,
    input logic          rst,
    mips_ctrl_ws_if.master bus
);

    state_e           state_q, state_d;
    logic [1:0]       err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_t            ctrl;
    logic             waiting;
    logic             expired;

    assign waiting = is_wait_state(state_q) && !bus.mem_ready;

    mips_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .waiting (waiting),
        .expired (expired)
    );

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        ctrl    = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_write  = bus.mem_ready;
                ctrl.pc_write  = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_d = S_DECODE;
                end else if (expired) begin
                    state_d = S_ERROR;
                    err_d   = ERR_TIMEOUT;
                end
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SL2;
                case (bus.opcode)
                    OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
                    OP_RTYPE:                         state_d = S_R_EXEC;
                    OP_BEQ:                           state_d = S_BEQ;
                    OP_J:                             state_d = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_I_EXEC;
                    OP_JAL: begin
                        if (HAS_JAL != 0) begin
                            state_d = S_JAL;
                        end else begin
                            state_d = S_ERROR;
                            err_d   = ERR_ILLEGAL;
                        end
                    end
                    default: begin
                        state_d = S_ERROR;
                        err_d   = ERR_ILLEGAL;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                state_d        = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (expired) begin
                    state_d = S_ERROR;
                    err_d   = ERR_TIMEOUT;
                end
            end
            S_MEM_WB: begin
                ctrl.reg_write     = 1'b1;
                ctrl.wreg_dst      = DST_RT;
                ctrl.wreg_data_sel = WD_MDR;
                state_d            = S_FETCH;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_FETCH;
                end else if (expired) begin
                    state_d = S_ERROR;
                    err_d   = ERR_TIMEOUT;
                end
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
                state_d        = S_R_WB;
            end
            S_R_WB: begin
                ctrl.reg_write     = 1'b1;
                ctrl.wreg_dst      = DST_RD;
                ctrl.wreg_data_sel = WD_ALUOUT;
                state_d            = S_FETCH;
            end
            S_BEQ: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                state_d            = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
                state_d        = S_FETCH;
            end
            S_JAL: begin
                ctrl.pc_write      = 1'b1;
                ctrl.pc_source     = PCSRC_JUMP;
                ctrl.reg_write     = 1'b1;
                ctrl.wreg_dst      = DST_R31;
                ctrl.wreg_data_sel = WD_PC;
                state_d            = S_FETCH;
            end
            S_I_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_IMM;
                ctrl.imm_com   = (bus.opcode == OP_ANDI) || (bus.opcode == OP_ORI);
                state_d        = S_I_WB;
            end
            S_I_WB: begin
                ctrl.reg_write     = 1'b1;
                ctrl.wreg_dst      = DST_RT;
                ctrl.wreg_data_sel = WD_ALUOUT;
                state_d            = S_FETCH;
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase
    end

    // An instruction retires when control returns to FETCH from a real instruction state.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_ERROR) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            err_q   <= ERR_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.alu_op        = ctrl.alu_op;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.pc_source     = ctrl.pc_source;
    assign bus.wreg_dst      = ctrl.wreg_dst;
    assign bus.wreg_data_sel = ctrl.wreg_data_sel;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.i_or_d        = ctrl.i_or_d;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.imm_com       = ctrl.imm_com;
    assign bus.state         = state_q;
    assign bus.error_code    = err_q;
    assign bus.instr_count   = cnt_q;

endmodule

// File: tb/tb_mips_ctrl_ws.sv
// Directed bench for mips_ctrl_ws: one instance with long timeout and a 4-bit
// counter, one with TIMEOUT=4 and jal disabled.
module tb_mips_ctrl_ws;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    int   vectors = 0;
    int   miscompares = 0;

    int lw_state [6] = '{0, 1, 2, 3, 4, 0};
    int lw_rw    [6] = '{0, 0, 0, 0, 1, 0};
    int lw_mrd   [6] = '{1, 0, 0, 1, 0, 1};
    int lw_iord  [6] = '{0, 0, 0, 1, 0, 0};

    mips_ctrl_ws_if #(.CNT_W(4)) bus ();
    mips_ctrl_ws_if #(.CNT_W(8)) bus2 ();

    mips_ctrl_ws #(.TIMEOUT(16), .CNT_W(4), .HAS_JAL(1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mips_ctrl_ws #(.TIMEOUT(4), .CNT_W(8), .HAS_JAL(0)) u_dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From FETCH with memory ready: advance through DECODE into the execute state.
    task automatic enter(input logic [5:0] op);
        bus.opcode    = op;
        bus.mem_ready = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        rst2           = 1'b1;
        bus.opcode     = 6'd0;
        bus.mem_ready  = 1'b0;
        bus2.opcode    = 6'd0;
        bus2.mem_ready = 1'b0;
        tick();
        tick();
        check("rst_state", bus.state, 0);
        check("rst_err", bus.error_code, 0);
        check("rst_cnt", bus.instr_count, 0);
        check("rst_fetch_mrd", bus.mem_read, 1);
        check("rst_fetch_srcb", bus.alu_src_b, 2'b01);
        check("rst_no_irw", bus.ir_write, 0);
        rst = 1'b0;

        // lw with memory always ready
        bus.opcode    = OP_LW;
        bus.mem_ready = 1'b1;
        #1;
        check("lw_irw", bus.ir_write, 1);
        check("lw_pcw", bus.pc_write, 1);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("lw_state%0d", i), bus.state, lw_state[i]);
            check($sformatf("lw_rw%0d", i), bus.reg_write, lw_rw[i]);
            check($sformatf("lw_mrd%0d", i), bus.mem_read, lw_mrd[i]);
            check($sformatf("lw_iord%0d", i), bus.i_or_d, lw_iord[i]);
            if (i == 4) check("lw_wb_sel", bus.wreg_data_sel, 2'b01);
            if (i < 5) tick();
        end
        check("lw_cnt", bus.instr_count, 1);

        // sw stalled five cycles in MEM_WR
        bus.opcode = OP_SW;
        tick();
        tick();
        check("sw_addr_state", bus.state, 2);
        check("sw_addr_srca", bus.alu_src_a, 1);
        check("sw_addr_srcb", bus.alu_src_b, 2'b10);
        bus.mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            if (i == 5) bus.mem_ready = 1'b1;
            #1;
            check($sformatf("sw_state%0d", i), bus.state, 5);
            check($sformatf("sw_mwr%0d", i), bus.mem_write, 1);
            check($sformatf("sw_iord%0d", i), bus.i_or_d, 1);
            check($sformatf("sw_mrd%0d", i), bus.mem_read, 0);
            tick();
        end
        check("sw_done_state", bus.state, 0);
        check("sw_cnt", bus.instr_count, 2);

        // R-type
        enter(OP_RTYPE);
        check("r_exec_state", bus.state, 6);
        check("r_exec_aluop", bus.alu_op, 2'b10);
        check("r_exec_srca", bus.alu_src_a, 1);
        check("r_exec_srcb", bus.alu_src_b, 2'b00);
        tick();
        check("r_wb_state", bus.state, 7);
        check("r_wb_rw", bus.reg_write, 1);
        check("r_wb_dst", bus.wreg_dst, 2'b01);
        check("r_wb_sel", bus.wreg_data_sel, 2'b00);
        tick();
        check("r_cnt", bus.instr_count, 3);

        // beq
        enter(OP_BEQ);
        check("beq_state", bus.state, 8);
        check("beq_pwc", bus.pc_write_cond, 1);
        check("beq_pcsrc", bus.pc_source, 2'b01);
        check("beq_aluop", bus.alu_op, 2'b01);
        check("beq_pcw", bus.pc_write, 0);
        tick();
        check("beq_cnt", bus.instr_count, 4);

        // jal
        enter(OP_JAL);
        check("jal_state", bus.state, 10);
        check("jal_pcw", bus.pc_write, 1);
        check("jal_pcsrc", bus.pc_source, 2'b10);
        check("jal_rw", bus.reg_write, 1);
        check("jal_dst", bus.wreg_dst, 2'b10);
        check("jal_sel", bus.wreg_data_sel, 2'b10);
        tick();
        check("jal_cnt", bus.instr_count, 5);

        // j
        enter(OP_J);
        check("j_state", bus.state, 9);
        check("j_pcw", bus.pc_write, 1);
        check("j_pcsrc", bus.pc_source, 2'b10);
        check("j_rw", bus.reg_write, 0);
        tick();
        check("j_cnt", bus.instr_count, 6);

        // ori (zero-extended) then addi (sign-extended)
        enter(OP_ORI);
        check("ori_state", bus.state, 11);
        check("ori_aluop", bus.alu_op, 2'b11);
        check("ori_imm_com", bus.imm_com, 1);
        check("ori_srcb", bus.alu_src_b, 2'b10);
        tick();
        check("ori_wb_state", bus.state, 12);
        check("ori_wb_rw", bus.reg_write, 1);
        check("ori_wb_dst", bus.wreg_dst, 2'b00);
        tick();
        check("ori_cnt", bus.instr_count, 7);
        enter(OP_ADDI);
        check("addi_state", bus.state, 11);
        check("addi_imm_com", bus.imm_com, 0);
        tick();
        tick();
        check("addi_cnt", bus.instr_count, 8);

        // reset in the middle of a MEM_RD wait
        bus.opcode = OP_LW;
        tick();
        tick();
        bus.mem_ready = 1'b0;
        tick();
        tick();
        check("rdwait_state", bus.state, 3);
        check("rdwait_mrd", bus.mem_read, 1);
        check("rdwait_iord", bus.i_or_d, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_state", bus.state, 0);
        check("midrst_cnt", bus.instr_count, 0);
        check("midrst_err", bus.error_code, 0);

        // 16 retirements wrap a 4-bit counter
        bus.opcode    = OP_J;
        bus.mem_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            tick();
            tick();
            if (k == 15) check("wrap_cnt15", bus.instr_count, 15);
        end
        check("wrap_cnt0", bus.instr_count, 0);
        check("wrap_state", bus.state, 0);

        // illegal opcode, then terminal ERROR
        bus.opcode = 6'b111111;
        tick();
        tick();
        check("ill_state", bus.state, 13);
        check("ill_err", bus.error_code, 2'b10);
        tick();
        tick();
        tick();
        check("ill_hold_state", bus.state, 13);
        check("ill_hold_err", bus.error_code, 2'b10);
        check("ill_mrd", bus.mem_read, 0);
        check("ill_irw", bus.ir_write, 0);
        check("ill_pcw", bus.pc_write, 0);
        check("ill_cnt", bus.instr_count, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("ill_rst_state", bus.state, 0);
        check("ill_rst_err", bus.error_code, 0);

        // second instance: mem_ready on the 4th stalled cycle still wins
        rst2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("to_edge_state%0d", i), bus2.state, 0);
        end
        bus2.mem_ready = 1'b1;
        bus2.opcode    = OP_JAL;
        tick();
        check("to_edge_decode", bus2.state, 1);
        tick();
        check("nojal_state", bus2.state, 13);
        check("nojal_err", bus2.error_code, 2'b10);

        // fetch timeout after four stalled cycles
        rst2 = 1'b1;
        tick();
        rst2           = 1'b0;
        bus2.mem_ready = 1'b0;
        check("to_rst_state", bus2.state, 0);
        check("to_rst_err", bus2.error_code, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("to_state%0d", i), bus2.state, (i < 3) ? 0 : 13);
        end
        check("to_err", bus2.error_code, 2'b01);
        check("to_mrd", bus2.mem_read, 0);
        check("to_irw", bus2.ir_write, 0);
        check("to_cnt", bus2.instr_count, 0);
        bus2.mem_ready = 1'b1;
        tick();
        tick();
        check("to_hold_state", bus2.state, 13);
        check("to_hold_err", bus2.error_code, 2'b01);
        check("to_hold_pcw", bus2.pc_write, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
